// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings, FSM states and op decode helper for seq_shifter
package shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Any encoding outside the five real ops returns the operand untouched.
    function automatic logic op_is_pass(input logic [2:0] op);
        return !(op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR});
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate of 0..STEP bits
module shift_step #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic [XLEN-1:0]      data_in,
    input  logic [$clog2(XLEN):0] amt,
    input  logic                 dir_right,
    input  logic                 fill,
    input  logic                 rotate,
    output logic [XLEN-1:0]      data_out
);

    localparam int AW = $clog2(XLEN) + 1;

    always_comb begin
        data_out = data_in;
        for (int i = 1; i <= STEP; i++) begin
            if (amt == AW'(i)) begin
                if (dir_right) begin
                    if (rotate)
                        data_out = (data_in >> i) | (data_in << (XLEN - i));
                    else
                        data_out = (data_in >> i) | (fill ? ~({XLEN{1'b1}} >> i) : '0);
                end else begin
                    if (rotate)
                        data_out = (data_in << i) | (data_in >> (XLEN - i));
                    else
                        data_out = data_in << i;
                end
            end
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter/rotator moving up to STEP bits per cycle
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         a,
    input  logic [2:0]              op,
    input  logic [$clog2(XLEN)-1:0] shamt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         result
);

    localparam int CW = $clog2(XLEN) + 1;

    state_t          state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            dir_q, dir_d;
    logic            rot_q, rot_d;
    logic            fill_q, fill_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic [CW-1:0]   step_k;
    logic [XLEN-1:0] step_out;

    always_comb begin
        step_k = (rem_q > CW'(STEP)) ? CW'(STEP) : rem_q;
    end

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .data_in   (data_q),
        .amt       (step_k),
        .dir_right (dir_q),
        .fill      (fill_q),
        .rotate    (rot_q),
        .data_out  (step_out)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rem_d       = rem_q;
        dir_d       = dir_q;
        rot_d       = rot_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d     = a;
                    dir_d      = op[0];
                    rot_d      = op[2];
                    fill_d     = (op == OP_SRA) && a[XLEN-1];
                    in_ready_d = 1'b0;
                    if (op_is_pass(op) || shamt == '0) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        rem_d   = {1'b0, shamt};
                    end
                end
            end
            ST_SHIFT: begin
                data_d = step_out;
                rem_d  = rem_q - step_k;
                if (rem_q == step_k) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                // Return through IDLE so a consume and an accept never share a cycle.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            dir_q       <= 1'b0;
            rot_q       <= 1'b0;
            fill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            dir_q       <= dir_d;
            rot_q       <= rot_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter over STEP = 1..32
module tb_seq_shifter;

    localparam int XLEN = 32;
    localparam int NI   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic [XLEN-1:0]   a;
    logic [2:0]        op;
    logic [4:0]        shamt;
    logic [NI-1:0]     in_ready_w;
    logic [NI-1:0]     out_valid_w;
    logic [XLEN-1:0]   result_w [NI];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_shifter #(
            .XLEN (XLEN),
            .STEP (1 << g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .a         (a),
            .op        (op),
            .shamt     (shamt),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .result    (result_w[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic is_real_op(input logic [2:0] o);
        return (o == 3'b000) || (o == 3'b001) || (o == 3'b011) || (o == 3'b100) || (o == 3'b101);
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [2:0] o, input int s);
        logic signed [31:0] sx;
        logic [31:0] r;
        sx = x;
        case (o)
            3'b000:  r = x << s;
            3'b001:  r = x >> s;
            3'b011:  r = sx >>> s;
            3'b100:  r = (x << s) | (x >> (32 - s));
            3'b101:  r = (x >> s) | (x << (32 - s));
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic int ref_cycles(input logic [2:0] o, input int s, input int step);
        if (!is_real_op(o)) return 0;
        return (s + step - 1) / step;
    endfunction

    // Broadcast one request to every instance and follow each to completion.
    task automatic run_op(input logic [31:0] ta, input logic [2:0] top, input int tsh,
                          input logic [31:0] texp, input int bp);
        int seen [NI];
        int maxlat;
        bit all_done;
        maxlat = ref_cycles(top, tsh, 1) + 1;
        for (int i = 0; i < NI; i++) begin
            seen[i] = 0;
            check_eq($sformatf("ready_pre s%0d", 1 << i), 32'(in_ready_w[i]), 32'd1);
        end
        a = ta; op = top; shamt = 5'(tsh); in_valid = 1'b1; out_ready = (bp == 0);
        all_done = 1'b0;
        for (int c = 1; c <= 120 && !all_done; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom; op = 3'($urandom_range(0, 7)); shamt = 5'($urandom_range(0, 31));
            all_done = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (out_valid_w[i]) begin
                    if (seen[i] == 0) begin
                        seen[i] = c;
                        check_eq($sformatf("latency s%0d op%0d sh%0d", 1 << i, top, tsh),
                                 32'(c), 32'(ref_cycles(top, tsh, 1 << i) + 1));
                    end
                    check_eq($sformatf("result s%0d op%0d sh%0d a%08h", 1 << i, top, tsh, ta),
                             result_w[i], texp);
                    check_eq($sformatf("ready_busy s%0d", 1 << i), 32'(in_ready_w[i]), 32'd0);
                end
                if (seen[i] == 0 || !in_ready_w[i]) all_done = 1'b0;
            end
            if (bp > 0) begin
                out_ready = (c >= maxlat + bp);
                if (!out_ready) in_valid = 1'($urandom_range(0, 1));
            end
        end
        check_eq("timeout", 32'(all_done), 32'd1);
    endtask

    initial begin
        int s;
        logic [2:0] o;
        logic [31:0] x;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; op = '0; shamt = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("rst in_ready s%0d", 1 << i), 32'(in_ready_w[i]), 32'd1);
            check_eq($sformatf("rst out_valid s%0d", 1 << i), 32'(out_valid_w[i]), 32'd0);
            check_eq($sformatf("rst result s%0d", 1 << i), result_w[i], 32'd0);
        end

        run_op(32'h0000_0001, 3'b000, 31, 32'h8000_0000, 0);
        run_op(32'h8000_00F0, 3'b011, 6,  32'hFE00_0003, 0);
        run_op(32'h1234_5678, 3'b101, 8,  32'h7812_3456, 0);
        run_op(32'hDEAD_BEEF, 3'b010, 5,  32'hDEAD_BEEF, 0);
        run_op(32'h8000_0001, 3'b100, 1,  32'h0000_0003, 0);
        run_op(32'h1234_5678, 3'b101, 8,  32'h7812_3456, 10);

        // Reset lands in the third SHIFT cycle of a STEP=1 op.
        a = 32'h0000_0001; op = 3'b000; shamt = 5'd20; in_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq($sformatf("rst_mid ov c%0d", c), 32'(out_valid_w[0]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("rst_mid in_ready s%0d", 1 << i), 32'(in_ready_w[i]), 32'd1);
            check_eq($sformatf("rst_mid out_valid s%0d", 1 << i), 32'(out_valid_w[i]), 32'd0);
        end
        @(negedge clk);
        check_eq("rst_mid ov after", 32'(out_valid_w[0]), 32'd0);
        run_op(32'hF000_0000, 3'b001, 4, 32'h0F00_0000, 0);

        for (int n = 0; n < 1700; n++) begin
            x = $urandom;
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       s = 0;
                1:       s = 31;
                default: s = $urandom_range(0, 31);
            endcase
            run_op(x, o, s, ref_shift(x, o, s), ($urandom_range(0, 15) == 0) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; power of two, 8..64.
REQ-002 SHALL have parameter STEP, default 1: maximum bits shifted per cycle; power of two, 1..XLEN.
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a  in  XLEN  operand.
- op  in  3  operation: bit0 direction (0 left, 1 right), bit1 arithmetic, bit2 rotate.
- shamt  in  log2(XLEN)  shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  shifted value.

Function
REQ-004 SHALL decode op as follows:
- 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR.
- 010, 110 and 111 SHALL be pass-through: result = a, treated as shamt = 0.
REQ-005 SHALL have FSM states IDLE, SHIFT and DONE.
REQ-006 SHALL assert in_ready only in IDLE; a request is accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL, on accept, capture a, op and shamt, and latch the sign bit a[XLEN-1] for SRA.
REQ-008 SHALL, on accept with an effective shamt of 0, go directly to DONE with result = a.
REQ-009 SHALL, on accept with effective shamt > 0, go to SHIFT with remaining = shamt.
REQ-010 SHALL, on each SHIFT cycle, shift the working value by k = min(STEP, remaining) and set remaining -= k; when remaining reaches 0, go to DONE.
REQ-011 SHALL fill vacated bits with 0 for SLL/SRL and with the latched sign for SRA; ROL/ROR SHALL wrap bits around with no loss.
REQ-012 SHALL assert out_valid in cycle accept+N+1, where N = ceil(shamt/STEP); N = 0 for pass-through.
REQ-013 SHALL assert out_valid only in DONE, holding result stable until out_valid && out_ready, then return to IDLE.
REQ-014 SHALL NOT accept a new request in the same cycle that a result is consumed; maximum throughput is one op per N+2 cycles.
REQ-015 SHALL ignore in_valid outside IDLE, and SHALL ignore changes on a, op or shamt after accept.
REQ-016 SHALL produce results bit-identical to single-cycle <<, >> and >>> semantics, and to rotate by shamt mod XLEN.

Reset
REQ-017 SHALL, when rst is high at a rising edge, enter IDLE with out_valid = 0, result = 0, in_ready = 1 on the following cycle.
REQ-018 SHALL, on rst during SHIFT or DONE, discard the in-flight operation with no result emitted; rst SHALL take priority over every other event.

Structure
REQ-019 SHALL take the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR) and the FSM state encoding from shared package shifter_pkg.
REQ-020 SHALL instantiate one combinational sub-module, shift_step, which performs one shift or rotate of 0..STEP bits on XLEN-bit data given direction, fill bit and rotate flag; the FSM, counter and handshake SHALL stay in seq_shifter.
REQ-021 SHALL size the remaining counter to log2(XLEN)+1 bits, with no combinational path from in_valid to in_ready.

Verification
REQ-022 SHALL cover SLL, XLEN=32, STEP=1: a=0x0000_0001, shamt=31 -> result 0x8000_0000, out_valid in cycle accept+32.
REQ-023 SHALL cover SRA, STEP=4: a=0x8000_00F0, shamt=6 -> result 0xFE00_0003, out_valid in cycle accept+3.
REQ-024 SHALL cover ROR, STEP=4: a=0x1234_5678, shamt=8 -> result 0x7812_3456; and op=010 with a=0xDEAD_BEEF, shamt=5 -> 0xDEAD_BEEF in cycle accept+1.
REQ-025 SHALL cover backpressure: out_ready held low for 10 cycles -> result stable, in_ready = 0 throughout, in_valid pulses ignored.
REQ-026 SHALL cover rst asserted in the 3rd SHIFT cycle of a shamt=20, STEP=1 op -> out_valid never rises, in_ready = 1 the next cycle, and a following SRL of 0xF000_0000 by 4 -> 0x0F00_0000.
REQ-027 SHALL cover a random self-check of 10k ops over all STEP values against a reference model, including shamt=0 and shamt=XLEN-1.
